dcache_nway: RTL

Parametrised N-way set-associative write-back data cache that replaces the fixed 2-way, 64-set, 256-bit-line data cache. It sits between the core memory stage and the block RAM port. Compared with that block it adds:
- configurable ways, sets and line size;
- per-byte write enables;
- deterministic victim selection;
- a strict RAM handshake in which requests are held until the RAM responds.

---
 rtl/dcache_nway.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_nway.sv
// N-way set-associative write-back data cache with a held-request RAM handshake.
// Define DCACHE_LRU_EN for true per-set LRU replacement; otherwise per-set round-robin.

module dcache_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dc_read_en,
    input  logic                     dc_write_en,
    input  logic [31:0]              dc_addr,
    input  logic [31:0]              dc_data,
    input  logic [3:0]               dc_byte_en,
    output logic                     mem_stall,
    output logic [31:0]              dc_data_out,
    output logic                     ram_en,
    output logic                     ram_write_en,
    output logic [31:0]              ram_addr,
    output logic [32*LINE_WORDS-1:0] ram_data,
    input  logic                     ram_ready,
    input  logic [32*LINE_WORDS-1:0] block_from_ram
);

    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int WORD_W = OFF_W - 2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_WRITEBACK, ST_REFILL, ST_RESPOND
    } state_t;

    state_t              state_r, state_nx_s;
    logic [31:2]         req_addr_r;
    logic [WAY_W-1:0]    victim_r;
    logic [31:0]         dout_r;
    logic                ram_en_r, ram_we_r;
    logic [31:0]         ram_addr_r;
    logic [LINE_W-1:0]   ram_data_r;
    logic                ram_en_nx_s, ram_we_nx_s;
    logic [31:0]         ram_addr_nx_s;
    logic [LINE_W-1:0]   ram_data_nx_s;

    logic [WAYS-1:0]     valid_r [SETS];
    logic [WAYS-1:0]     dirty_r [SETS];
    logic [TAG_W-1:0]    tag_r   [WAYS][SETS];
    logic [LINE_W-1:0]   line_r  [WAYS][SETS];
`ifdef DCACHE_LRU_EN
    logic [WAY_W-1:0]    age_r   [SETS][WAYS];
`else
    logic [WAY_W-1:0]    rr_r    [SETS];
`endif

    logic                req_s, lookup_s, fill_s, hit_s, inv_s, victim_dirty_s;
    logic [WAYS-1:0]     match_s;
    logic [WAY_W-1:0]    hit_way_s, inv_way_s, pol_way_s, victim_s;
    logic [TAG_W-1:0]    req_tag_s;
    logic [IDX_W-1:0]    req_idx_s;
    logic [WORD_W-1:0]   req_word_s;
    logic [LINE_W-1:0]   sel_line_s;
    logic [31:0]         rd_word_s, wr_word_s;
    logic                unused_addr_s;

    // The request address is latched in IDLE so RAM outputs stay stable even if the core drops the request
    assign req_tag_s     = req_addr_r[31 -: TAG_W];
    assign req_idx_s     = req_addr_r[OFF_W +: IDX_W];
    assign req_word_s    = req_addr_r[2 +: WORD_W];
    assign unused_addr_s = &{1'b0, dc_addr[1:0]};

    assign req_s    = dc_read_en | dc_write_en;
    assign lookup_s = (state_r == ST_LOOKUP) && req_s;
    assign fill_s   = (state_r == ST_REFILL) && ram_ready;

    // Tag compare and victim choice; descending loops let the lowest matching way win
    always_comb begin
        match_s   = '0;
        hit_s     = 1'b0;
        hit_way_s = '0;
        inv_s     = 1'b0;
        inv_way_s = '0;
        pol_way_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            match_s[w] = valid_r[req_idx_s][w] && (tag_r[w][req_idx_s] == req_tag_s);
            hit_s      = hit_s | match_s[w];
            hit_way_s  = match_s[w] ? WAY_W'(w) : hit_way_s;
            inv_s      = inv_s | ~valid_r[req_idx_s][w];
            inv_way_s  = valid_r[req_idx_s][w] ? inv_way_s : WAY_W'(w);
        end
`ifdef DCACHE_LRU_EN
        for (int w = 1; w < WAYS; w++) begin
            pol_way_s = (age_r[req_idx_s][w] > age_r[req_idx_s][pol_way_s]) ? WAY_W'(w) : pol_way_s;
        end
`else
        pol_way_s = rr_r[req_idx_s];
`endif
        victim_s = inv_s ? inv_way_s : pol_way_s;
    end

    assign victim_dirty_s = valid_r[req_idx_s][victim_s] & dirty_r[req_idx_s][victim_s];
    assign sel_line_s     = line_r[hit_way_s][req_idx_s];
    assign rd_word_s      = sel_line_s[{req_word_s, 5'd0} +: 32];

    // Byte-masked merge of write data into the hit word
    always_comb begin
        wr_word_s = rd_word_s;
        for (int b = 0; b < 4; b++) begin
            wr_word_s[8*b +: 8] = dc_byte_en[b] ? dc_data[8*b +: 8] : rd_word_s[8*b +: 8];
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) state_nx_s = ST_LOOKUP;
                else       state_nx_s = ST_IDLE;
            end
            ST_LOOKUP: begin
                if (!req_s)              state_nx_s = ST_IDLE;
                else if (hit_s)          state_nx_s = ST_RESPOND;
                else if (victim_dirty_s) state_nx_s = ST_WRITEBACK;
                else                     state_nx_s = ST_REFILL;
            end
            ST_WRITEBACK: begin
                if (ram_ready) state_nx_s = ST_REFILL;
                else           state_nx_s = ST_WRITEBACK;
            end
            ST_REFILL: begin
                if (ram_ready) state_nx_s = req_s ? ST_LOOKUP : ST_IDLE;
                else           state_nx_s = ST_REFILL;
            end
            ST_RESPOND: state_nx_s = ST_IDLE;
            default:    state_nx_s = ST_IDLE;
        endcase
    end

    // RAM request values for the coming state; the victim line is captured only on entry
    always_comb begin
        ram_en_nx_s   = 1'b0;
        ram_we_nx_s   = 1'b0;
        ram_addr_nx_s = 32'h0;
        ram_data_nx_s = '0;
        case (state_nx_s)
            ST_WRITEBACK: begin
                ram_en_nx_s = 1'b1;
                ram_we_nx_s = 1'b1;
                if (state_r == ST_LOOKUP) begin
                    ram_addr_nx_s = {tag_r[victim_s][req_idx_s], req_idx_s, {OFF_W{1'b0}}};
                    ram_data_nx_s = line_r[victim_s][req_idx_s];
                end else begin
                    ram_addr_nx_s = ram_addr_r;
                    ram_data_nx_s = ram_data_r;
                end
            end
            ST_REFILL: begin
                ram_en_nx_s   = 1'b1;
                ram_addr_nx_s = {req_tag_s, req_idx_s, {OFF_W{1'b0}}};
            end
            default: ram_en_nx_s = 1'b0;
        endcase
    end

    // Control state, request latch, read data and registered RAM outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            req_addr_r <= 30'h0;
            victim_r   <= '0;
            dout_r     <= 32'h0;
            ram_en_r   <= 1'b0;
            ram_we_r   <= 1'b0;
            ram_addr_r <= 32'h0;
            ram_data_r <= '0;
        end else begin
            state_r    <= state_nx_s;
            ram_en_r   <= ram_en_nx_s;
            ram_we_r   <= ram_we_nx_s;
            ram_addr_r <= ram_addr_nx_s;
            ram_data_r <= ram_data_nx_s;
            if (state_r == ST_IDLE && req_s) req_addr_r <= dc_addr[31:2];
            if (lookup_s && !hit_s)          victim_r   <= victim_s;
            if (lookup_s && hit_s && !dc_write_en) dout_r <= rd_word_s;
        end
    end

    // Valid, dirty and replacement state; all cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
`ifdef DCACHE_LRU_EN
                for (int w = 0; w < WAYS; w++) age_r[s][w] <= '0;
`else
                rr_r[s] <= '0;
`endif
            end
        end else begin
            if (fill_s) begin
                valid_r[req_idx_s][victim_r] <= 1'b1;
                dirty_r[req_idx_s][victim_r] <= 1'b0;
            end
            if (lookup_s && hit_s && dc_write_en) dirty_r[req_idx_s][hit_way_s] <= 1'b1;
`ifdef DCACHE_LRU_EN
            // Equal ages count as younger so ages separate from the all-zero reset state
            if (lookup_s && hit_s) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == hit_way_s) begin
                        age_r[req_idx_s][w] <= '0;
                    end else if (age_r[req_idx_s][w] <= age_r[req_idx_s][hit_way_s] &&
                                 age_r[req_idx_s][w] != WAY_W'(WAYS - 1)) begin
                        age_r[req_idx_s][w] <= age_r[req_idx_s][w] + 1'b1;
                    end
                end
            end
`else
            if (lookup_s && !hit_s && !inv_s) begin
                rr_r[req_idx_s] <= (rr_r[req_idx_s] == WAY_W'(WAYS - 1)) ? '0 : rr_r[req_idx_s] + 1'b1;
            end
`endif
        end
    end

    // Tag and line storage; not reset because valid bits gate every use
    always_ff @(posedge clk) begin
        if (fill_s) begin
            line_r[victim_r][req_idx_s] <= block_from_ram;
            tag_r[victim_r][req_idx_s]  <= req_tag_s;
        end else if (lookup_s && hit_s && dc_write_en) begin
            line_r[hit_way_s][req_idx_s][{req_word_s, 5'd0} +: 32] <= wr_word_s;
        end
    end

    assign mem_stall    = req_s & (state_r != ST_RESPOND);
    assign dc_data_out  = dout_r;
    assign ram_en       = ram_en_r;
    assign ram_write_en = ram_we_r;
    assign ram_addr     = ram_addr_r;
    assign ram_data     = ram_data_r;

endmodule
